// File: rtl/alu_pkg.sv
// Shared opcodes, FSM states and flag bundle for the sequential ALU.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_ADC  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_SBC  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_NOT  = 4'd7;
  localparam logic [3:0] OP_SHL1 = 4'd8;
  localparam logic [3:0] OP_SHR1 = 4'd9;
  localparam logic [3:0] OP_SHL  = 4'd10;
  localparam logic [3:0] OP_SHR  = 4'd11;
  localparam logic [3:0] OP_NAND = 4'd12;
  localparam logic [3:0] OP_NOR  = 4'd13;
  localparam logic [3:0] OP_XNOR = 4'd14;
  localparam logic [3:0] OP_MUL  = 4'd15;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  typedef struct packed {
    logic carry;
    logic overflow;
    logic zero;
    logic negative;
  } flags_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add unsigned multiplier: one partial product per cycle, WIDTH cycles after start.
module alu_mul_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               run_q, run_d;

  always_comb begin
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    done_o   = 1'b0;
    if (start_i) begin
      mcand_d  = {{WIDTH{1'b0}}, a_i};
      mplier_d = b_i;
      acc_d    = '0;
      cnt_d    = '0;
      run_d    = 1'b1;
    end else if (run_q) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == LastCnt) begin
        done_o = 1'b1;
        run_d  = 1'b0;
      end
    end
  end

  // Final product is presented in the same cycle as the last partial product.
  assign product_o = acc_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with valid/ready handshake, carry chaining and optional sequential multiply.
module seq_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic [3:0]       Mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_flag,
  output logic             overflow_flag,
  output logic             zero_flag,
  output logic             negative_flag
);

  localparam logic [WIDTH-1:0] WVal = WIDTH'(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  flags_t           flags_q, flags_d;
  logic             c_q, c_d;

  logic               accept, pop, is_mul, mul_start, mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  logic [WIDTH-1:0]   alu_res;
  flags_t             alu_flags;
  logic [WIDTH:0]     sum, diff;
  logic               cin_sel;

  assign out_valid = (state_q == StDone);
  assign in_ready  = (state_q != StBusy) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign is_mul    = MUL_EN && (Mode == OP_MUL);
  assign mul_start = accept && is_mul;

  if (MUL_EN) begin : g_mul
    alu_mul_seq #(
      .WIDTH(WIDTH)
    ) u_mul (
      .clk_i    (clk),
      .rst_i    (rst),
      .start_i  (mul_start),
      .a_i      (A),
      .b_i      (B),
      .done_o   (mul_done),
      .product_o(mul_prod)
    );
  end else begin : g_no_mul
    assign mul_done = 1'b0;
    assign mul_prod = '0;
  end

  // ADC/SBC chain through the carry register instead of the Cin port.
  assign cin_sel = ((Mode == OP_ADC) || (Mode == OP_SBC)) ? c_q : Cin;
  assign sum     = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, cin_sel};
  assign diff    = {1'b0, A} - {1'b0, B} - {{WIDTH{1'b0}}, cin_sel};

  always_comb begin
    alu_res            = '0;
    alu_flags          = '0;
    case (Mode)
      OP_ADD, OP_ADC: begin
        alu_res            = sum[WIDTH-1:0];
        alu_flags.carry    = sum[WIDTH];
        alu_flags.overflow = (A[WIDTH-1] == B[WIDTH-1]) && (alu_res[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB, OP_SBC: begin
        alu_res            = diff[WIDTH-1:0];
        alu_flags.carry    = diff[WIDTH];
        alu_flags.overflow = (A[WIDTH-1] != B[WIDTH-1]) && (alu_res[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND:  alu_res = A & B;
      OP_OR:   alu_res = A | B;
      OP_XOR:  alu_res = A ^ B;
      OP_NOT:  alu_res = ~A;
      OP_SHL1: begin
        alu_res         = A << 1;
        alu_flags.carry = A[WIDTH-1];
      end
      OP_SHR1: begin
        alu_res         = A >> 1;
        alu_flags.carry = A[0];
      end
      OP_SHL:  alu_res = (B >= WVal) ? '0 : (A << B);
      OP_SHR:  alu_res = (B >= WVal) ? '0 : (A >> B);
      OP_NAND: alu_res = ~(A & B);
      OP_NOR:  alu_res = ~(A | B);
      OP_XNOR: alu_res = ~(A ^ B);
      default: alu_res = '0;
    endcase
    alu_flags.zero     = (alu_res == '0);
    alu_flags.negative = alu_res[WIDTH-1];
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flags_d  = flags_q;
    c_d      = c_q;
    case (state_q)
      StIdle, StDone: begin
        if (accept) begin
          if (is_mul) begin
            state_d = StBusy;
          end else begin
            state_d  = StDone;
            result_d = alu_res;
            flags_d  = alu_flags;
            c_d      = alu_flags.carry;
          end
        end else if (pop) begin
          state_d = StIdle;
        end
      end
      StBusy: begin
        if (mul_done) begin
          state_d          = StDone;
          result_d         = mul_prod[WIDTH-1:0];
          flags_d.carry    = (mul_prod[2*WIDTH-1:WIDTH] != '0);
          flags_d.overflow = flags_d.carry;
          flags_d.zero     = (mul_prod[WIDTH-1:0] == '0);
          flags_d.negative = mul_prod[WIDTH-1];
          c_d              = flags_d.carry;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      result_q <= '0;
      flags_q  <= '0;
      c_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      c_q      <= c_d;
    end
  end

  assign result        = result_q;
  assign carry_flag    = flags_q.carry;
  assign overflow_flag = flags_q.overflow;
  assign zero_flag     = flags_q.zero;
  assign negative_flag = flags_q.negative;

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu at WIDTH=8.
module tb_seq_alu;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] A, B;
  logic       Cin;
  logic [3:0] Mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       carry_flag, overflow_flag, zero_flag, negative_flag;

  int checks = 0;
  int errors = 0;
  int cyc;
  int busy_ready;

  seq_alu #(
    .WIDTH (8),
    .MUL_EN(1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .A            (A),
    .B            (B),
    .Cin          (Cin),
    .Mode         (Mode),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .carry_flag   (carry_flag),
    .overflow_flag(overflow_flag),
    .zero_flag    (zero_flag),
    .negative_flag(negative_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] r, input logic c, input logic v,
                         input logic z, input logic n);
    chk({tag, ".valid"}, {15'd0, out_valid}, 16'd1);
    chk({tag, ".result"}, {8'd0, result}, {8'd0, r});
    chk({tag, ".flags"}, {12'd0, carry_flag, overflow_flag, zero_flag, negative_flag},
        {12'd0, c, v, z, n});
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic issue(input string tag, input logic [3:0] m, input logic [7:0] a,
                       input logic [7:0] b, input logic ci);
    Mode     = m;
    A        = a;
    B        = b;
    Cin      = ci;
    in_valid = 1'b1;
    #1;
    chk({tag, ".in_ready"}, {15'd0, in_ready}, 16'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_mul(input string tag);
    cyc        = 1;
    busy_ready = 0;
    while (!out_valid && cyc < 50) begin
      if (in_ready) busy_ready++;
      @(negedge clk);
      cyc++;
    end
    chk({tag, ".latency"}, 16'(cyc), 16'd9);
    chk({tag, ".busy_ready"}, 16'(busy_ready), 16'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    A         = '0;
    B         = '0;
    Cin       = 1'b0;
    Mode      = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset.valid", {15'd0, out_valid}, 16'd0);
    chk("reset.result", {8'd0, result}, 16'd0);
    chk("reset.flags", {12'd0, carry_flag, overflow_flag, zero_flag, negative_flag}, 16'd0);
    chk("reset.in_ready", {15'd0, in_ready}, 16'd1);

    issue("add", 4'd0, 8'hFF, 8'hFF, 1'b1);
    chk_out("add", 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);
    issue("sub_borrow", 4'd2, 8'h00, 8'h01, 1'b0);
    chk_out("sub_borrow", 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);
    issue("sub_ovf", 4'd2, 8'h80, 8'h01, 1'b0);
    chk_out("sub_ovf", 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0);

    issue("chain_add", 4'd0, 8'hFF, 8'h01, 1'b0);
    chk_out("chain_add", 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    issue("chain_adc", 4'd1, 8'h00, 8'h00, 1'b0);
    chk_out("chain_adc", 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);

    issue("shl1", 4'd8, 8'h81, 8'h00, 1'b0);
    chk_out("shl1", 8'h02, 1'b1, 1'b0, 1'b0, 1'b0);
    issue("sbc", 4'd3, 8'h05, 8'h02, 1'b0);
    chk_out("sbc", 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
    issue("not", 4'd7, 8'h0F, 8'h00, 1'b0);
    chk_out("not", 8'hF0, 1'b0, 1'b0, 1'b0, 1'b1);
    issue("shr_b", 4'd11, 8'h80, 8'h03, 1'b0);
    chk_out("shr_b", 8'h10, 1'b0, 1'b0, 1'b0, 1'b0);
    issue("shl_b9", 4'd10, 8'h01, 8'h09, 1'b0);
    chk_out("shl_b9", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

    issue("mul1", 4'd15, 8'h10, 8'h20, 1'b0);
    wait_mul("mul1");
    chk_out("mul1", 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    issue("mul2", 4'd15, 8'h0F, 8'h03, 1'b0);
    wait_mul("mul2");
    chk_out("mul2", 8'h2D, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);

    out_ready = 1'b0;
    issue("bp_and", 4'd4, 8'hF0, 8'h3C, 1'b0);
    chk_out("bp_and", 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk_out("bp_hold", 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("bp_hold.in_ready", {15'd0, in_ready}, 16'd0);
    out_ready = 1'b1;
    issue("bp_xor", 4'd6, 8'hAA, 8'h55, 1'b0);
    chk_out("bp_xor", 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);

    issue("pre_rst_add", 4'd0, 8'hFF, 8'h01, 1'b0);
    chk_out("pre_rst_add", 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    issue("rst_mul", 4'd15, 8'h03, 8'h03, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst.valid", {15'd0, out_valid}, 16'd0);
    chk("mid_rst.result", {8'd0, result}, 16'd0);
    chk("mid_rst.flags", {12'd0, carry_flag, overflow_flag, zero_flag, negative_flag}, 16'd0);
    chk("mid_rst.in_ready", {15'd0, in_ready}, 16'd1);
    repeat (10) @(negedge clk);
    chk("mid_rst.no_output", {15'd0, out_valid}, 16'd0);
    issue("post_rst_adc", 4'd1, 8'h00, 8'h00, 1'b1);
    chk_out("post_rst_adc", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
